// File: rtl/image_gen.sv
// Parametrised RGB pattern generator: checkerboard, fractal window and scrolling gradient,
// with frame-synchronous mode switching. Define IMAGE_GEN_BORDER_EN to add a white screen border.
module image_gen #(
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int CW          = 4,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int CELL_LOG2   = 2,
    parameter int COLOR_DIV   = 0,
    parameter int FRAC_LEVELS = 4,
    parameter int FRAC_X0     = 64,
    parameter int FRAC_Y_OFF  = 16,
    parameter int SCROLL_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] position_x_NEXT,
    input  logic [YW-1:0] position_y_NEXT,
    input  logic          frame_tick,
    input  logic [1:0]    mode_data,
    input  logic          mode_valid,
    output logic          mode_ready,
    output logic [1:0]    active_mode,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b
);

    typedef enum logic [1:0] {
        MODE_CHECKER  = 2'd0,
        MODE_FRACTAL  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_e;

    localparam int FW    = 2 * FRAC_LEVELS;
    localparam int DIV_W = (COLOR_DIV > 0) ? COLOR_DIV : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((1 << COLOR_DIV) - 1);
    localparam logic [XW-1:0]    X_LIM   = XW'(H_ACTIVE);
    localparam logic [YW-1:0]    Y_LIM   = YW'(V_ACTIVE);
    localparam logic [XW:0]      FX_LO   = (XW+1)'(FRAC_X0);
    localparam logic [XW:0]      FX_HI   = (XW+1)'(FRAC_X0 + (1 << FW));

    mode_e             active_q, active_d;
    mode_e             pend_mode_q, pend_mode_d;
    logic              pend_q, pend_d;
    logic [XW-1:0]     scroll_q, scroll_d;
    logic [2:0]        cidx_q, cidx_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [CW-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;

    logic              visible;
    logic              on_cell;
    logic              in_window;
    logic              frac_white;
    logic [FW-1:0]     sx, sy;
    logic [CW-1:0]     grad_r, grad_g;

    // Handshake and frame counters. The ready flag is simply "no request parked".
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        active_d    = active_q;
        pend_mode_d = pend_mode_q;
        pend_d      = pend_q;
        scroll_d    = scroll_q;
        cidx_d      = cidx_q;
        div_d       = div_q;

        if (frame_tick) begin
            scroll_d = scroll_q + XW'(SCROLL_STEP);
            if (div_q == DIV_MAX) begin
                div_d  = '0;
                cidx_d = (cidx_q == 3'd7) ? 3'd1 : cidx_q + 3'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
            // Only a request parked before this tick is applied.
            if (pend_q) begin
                active_d = pend_mode_q;
                pend_d   = 1'b0;
            end
        end

        if (mode_valid && !pend_q) begin
            pend_d      = 1'b1;
            pend_mode_d = mode_e'(mode_data);
        end
    end

    // Pixel pattern for the coordinates presented this cycle.
    always_comb begin
        visible   = (position_x_NEXT < X_LIM) && (position_y_NEXT < Y_LIM);
        on_cell   = position_x_NEXT[CELL_LOG2] ^ position_y_NEXT[CELL_LOG2];

        in_window = ({1'b0, position_x_NEXT} >= FX_LO) && ({1'b0, position_x_NEXT} < FX_HI);
        sx        = FW'(position_x_NEXT - XW'(FRAC_X0));
        sy        = FW'(position_y_NEXT + YW'(FRAC_Y_OFF));
        frac_white = in_window;
        for (int k = 0; k < FRAC_LEVELS; k++) begin
            if ((sx[2*k+1] == sx[2*k]) && (sy[2*k+1] == sy[2*k]))
                frac_white = 1'b0;
        end

        grad_r = CW'((position_x_NEXT + scroll_q) >> (XW - CW));
        grad_g = position_y_NEXT[YW-1 -: CW];

        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (visible) begin
            unique case (active_q)
                MODE_CHECKER: begin
                    r_d = {CW{on_cell & cidx_q[1]}};
                    g_d = {CW{on_cell & cidx_q[0]}};
                    b_d = {CW{on_cell & cidx_q[2]}};
                end
                MODE_FRACTAL: begin
                    r_d = {CW{frac_white}};
                    g_d = {CW{frac_white}};
                    b_d = {CW{frac_white}};
                end
                MODE_GRADIENT: begin
                    r_d = grad_r;
                    g_d = grad_g;
                    b_d = grad_r ^ grad_g;
                end
                MODE_RESERVED: ;
            endcase
`ifdef IMAGE_GEN_BORDER_EN
            if ((position_x_NEXT == '0) || (position_x_NEXT == X_LIM - XW'(1)) ||
                (position_y_NEXT == '0) || (position_y_NEXT == Y_LIM - YW'(1))) begin
                r_d = '1;
                g_d = '1;
                b_d = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            active_q    <= MODE_CHECKER;
            pend_mode_q <= MODE_CHECKER;
            pend_q      <= 1'b0;
            scroll_q    <= '0;
            cidx_q      <= 3'b111;
            div_q       <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            active_q    <= active_d;
            pend_mode_q <= pend_mode_d;
            pend_q      <= pend_d;
            scroll_q    <= scroll_d;
            cidx_q      <= cidx_d;
            div_q       <= div_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign mode_ready  = !pend_q;
    assign active_mode = active_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;

endmodule

// File: tb/tb_image_gen.sv
// Directed bench for image_gen: reset, checkerboard colour cycling, mode handshake,
// fractal window, gradient scroll and reserved mode. Honours IMAGE_GEN_BORDER_EN.
module tb_image_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] px;
    logic [8:0] py;
    logic       frame_tick;
    logic [1:0] mode_data;
    logic       mode_valid;
    logic       mode_ready;
    logic [1:0] active_mode;
    logic [3:0] r, g, b;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IMAGE_GEN_BORDER_EN
    localparam logic [3:0] BRD = 4'hF;
`else
    localparam logic [3:0] BRD = 4'h0;
`endif

    always #5 clk = ~clk;

    image_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .position_x_NEXT (px),
        .position_y_NEXT (py),
        .frame_tick      (frame_tick),
        .mode_data       (mode_data),
        .mode_valid      (mode_valid),
        .mode_ready      (mode_ready),
        .active_mode     (active_mode),
        .r               (r),
        .g               (g),
        .b               (b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [3:0] er, input logic [3:0] eg,
                             input logic [3:0] eb);
        check({tag, ".r"}, {4'h0, r}, {4'h0, er});
        check({tag, ".g"}, {4'h0, g}, {4'h0, eg});
        check({tag, ".b"}, {4'h0, b}, {4'h0, eb});
    endtask

    task automatic pix(input logic [9:0] x, input logic [8:0] y);
        px = x;
        py = y;
        step();
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic request(input logic [1:0] m);
        mode_valid = 1'b1;
        mode_data  = m;
        step();
        mode_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        px         = 10'd4;
        py         = 9'd0;
        frame_tick = 1'b0;
        mode_data  = 2'd0;
        mode_valid = 1'b0;
        step();
        step();
        check_rgb("reset", 4'h0, 4'h0, 4'h0);
        check("reset.mode", {6'd0, active_mode}, 8'd0);
        check("reset.ready", {7'd0, mode_ready}, 8'd1);
        rst_n = 1'b1;

        // Checkerboard, cidx = 7 (white cells)
        pix(10'd4, 9'd0);   check_rgb("chk_on", 4'hF, 4'hF, 4'hF);
        pix(10'd4, 9'd4);   check_rgb("chk_off", 4'h0, 4'h0, 4'h0);
        pix(10'd700, 9'd1); check_rgb("chk_x_invis", 4'h0, 4'h0, 4'h0);
        pix(10'd4, 9'd480); check_rgb("chk_y_invis", 4'h0, 4'h0, 4'h0);

        // Colour index walks 7 -> 1 -> 2 ... -> 7
        frame();
        pix(10'd4, 9'd1);   check_rgb("chk_cidx1", 4'h0, 4'hF, 4'h0);
        frame();
        pix(10'd4, 9'd1);   check_rgb("chk_cidx2", 4'hF, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) frame();
        pix(10'd4, 9'd1);   check_rgb("chk_cidx7", 4'hF, 4'hF, 4'hF);

        // Handshake: accept, ignore while busy, apply on the next tick
        request(2'd1);
        check("hs.ready_low", {7'd0, mode_ready}, 8'd0);
        check("hs.mode_hold", {6'd0, active_mode}, 8'd0);
        request(2'd2);
        step();
        check("hs.still_busy", {7'd0, mode_ready}, 8'd0);
        check("hs.no_tick", {6'd0, active_mode}, 8'd0);
        frame();
        check("hs.applied", {6'd0, active_mode}, 8'd1);
        check("hs.ready_back", {7'd0, mode_ready}, 8'd1);

        // Fractal window
        pix(10'd63, 9'd1);  check_rgb("frac_left", 4'h0, 4'h0, 4'h0);
        pix(10'd64, 9'd0);  check_rgb("frac_origin", BRD, BRD, BRD);
        pix(10'd149, 9'd0); check_rgb("frac_white", 4'hF, 4'hF, 4'hF);
        pix(10'd576, 9'd1); check_rgb("frac_right", 4'h0, 4'h0, 4'h0);
        pix(10'd700, 9'd1); check_rgb("frac_invis", 4'h0, 4'h0, 4'h0);

        // Reset mid-frame drops a parked request
        request(2'd3);
        check("rst.pending", {7'd0, mode_ready}, 8'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst.ready", {7'd0, mode_ready}, 8'd1);
        check("rst.mode", {6'd0, active_mode}, 8'd0);
        frame();
        check("rst.no_apply", {6'd0, active_mode}, 8'd0);

        // Gradient after 3 ticks since reset in total: scroll = 3
        request(2'd2);
        frame();
        check("grad.mode", {6'd0, active_mode}, 8'd2);
        frame();
        pix(10'd0, 9'd10);    check_rgb("grad_x0", BRD, BRD, BRD);
        pix(10'd100, 9'd200); check_rgb("grad_mid", 4'h1, 4'h6, 4'h7);
        pix(10'd639, 9'd10);
        if (BRD == 4'hF) check_rgb("grad_xmax", 4'hF, 4'hF, 4'hF);
        else             check_rgb("grad_xmax", 4'hA, 4'h0, 4'hA);
        pix(10'd1023, 9'd10); check_rgb("grad_invis", 4'h0, 4'h0, 4'h0);

        // Request accepted on the same edge as a tick waits for the next tick
        mode_valid = 1'b1;
        mode_data  = 2'd3;
        frame_tick = 1'b1;
        step();
        mode_valid = 1'b0;
        frame_tick = 1'b0;
        check("same.mode", {6'd0, active_mode}, 8'd2);
        check("same.ready", {7'd0, mode_ready}, 8'd0);
        step();
        check("same.hold", {6'd0, active_mode}, 8'd2);
        frame();
        check("same.applied", {6'd0, active_mode}, 8'd3);

        // Reserved mode renders black
        pix(10'd100, 9'd200); check_rgb("mode3", 4'h0, 4'h0, 4'h0);
        pix(10'd0, 9'd10);    check_rgb("mode3_edge", BRD, BRD, BRD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
